// File: rtl/online_arith_pkg.sv
// Shared definitions for the signed-digit online arithmetic blocks.
// Latency: none (types, constants and a pure function only).
// Backpressure: not applicable.
package online_arith_pkg;

  localparam logic [1:0] SD_ZERO = 2'b00;
  localparam logic [1:0] SD_POS  = 2'b01;
  localparam logic [1:0] SD_NEG  = 2'b10;
  localparam logic [1:0] SD_ILL  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_FLUSH
  } sqrt_state_e;

  // Maps a digit code to -1/0/+1; the illegal code reads as zero.
  function automatic logic signed [1:0] sd_to_int(input logic [1:0] code);
    case (code)
      SD_POS:  return 2'sd1;
      SD_NEG:  return -2'sd1;
      default: return 2'sd0;
    endcase
  endfunction

endpackage

// File: rtl/sd_sqrt_select.sv
// Root-digit selection from the 2-fractional-bit residual estimate.
// Latency: combinational.
// Backpressure: none; pure function of its input.
module sd_sqrt_select
  import online_arith_pkg::*;
(
  input  logic signed [4:0] vest_i,
  output logic signed [1:0] s_o,
  output logic [1:0]        code_o
);

  // Thresholds at +1/2 and -1/2, expressed in quarter units.
  always_comb begin
    s_o    = 2'sd0;
    code_o = SD_ZERO;
    if (vest_i >= 5'sd2) begin
      s_o    = 2'sd1;
      code_o = SD_POS;
    end else if (vest_i < -5'sd2) begin
      s_o    = -2'sd1;
      code_o = SD_NEG;
    end
  end

endmodule

// File: rtl/online_sqrt_n.sv
// Radix-2 MSD-first online square root, N digits in, N digits out.
// Latency: first root digit P accepted digits + 1 cycle after the first operand digit.
// Backpressure: i_valid low in LOAD/RUN freezes all state; FLUSH runs without input.
module online_sqrt_n
  import online_arith_pkg::*;
#(
  parameter int N     = 8,
  parameter int P     = 1,
  parameter int GUARD = 3
) (
  input  logic       i_clk,
  input  logic       i_Reset,
  input  logic       i_valid,
  input  logic       i_first,
  input  logic [1:0] i_x,
  output logic       o_valid,
  output logic [1:0] o_y,
  output logic       o_last,
  output logic       o_busy,
  output logic       o_err
);

  // Residual and partial root: 3 integer bits plus F fractional bits.
  localparam int F  = N + P + GUARD;
  localparam int WW = F + 3;
  localparam int JW = $clog2(N + 1);
  localparam int CW = $clog2(P + 1);

  localparam logic [WW-1:0] ONE_F = WW'(1) << F;
  localparam logic [WW-1:0] ONE_P = WW'(1) << (F - P);

  sqrt_state_e   state_q;
  logic [WW-1:0] w_q;
  logic [WW-1:0] s_q;
  logic [JW-1:0] j_q;
  logic [CW-1:0] ld_cnt_q;
  logic          valid_q;
  logic [1:0]    y_q;
  logic          last_q;
  logic          busy_q;
  logic          err_q;

  logic [1:0]        x_code;
  logic signed [1:0] x_int;
  logic              x_ill;
  logic [WW-1:0]     x_term;
  logic [WW-1:0]     v_d;
  logic [WW-1:0]     t_term;
  logic [WW-1:0]     two_s;
  logic [WW-1:0]     w_d;
  logic [WW-1:0]     s_d;
  logic [JW-1:0]     j_d;
  logic signed [4:0] vest;
  logic signed [1:0] sel;
  logic [1:0]        sel_code;

  // One recurrence step: V, digit selection inputs and the W/S updates.
  always_comb begin
    x_code = (state_q == ST_FLUSH) ? SD_ZERO : i_x;
    x_ill  = (x_code == SD_ILL);
    x_int  = sd_to_int(x_code);
    x_term = '0;
    if (x_int == 2'sd1) begin
      x_term = ONE_P;
    end else if (x_int == -2'sd1) begin
      x_term = '0 - ONE_P;
    end
    j_d    = j_q + JW'(1);
    t_term = ONE_F >> j_d;
    v_d    = (w_q << 1) + x_term;
    vest   = $signed(v_d[WW-1 -: 5]);
    two_s  = s_q << 1;
    w_d    = v_d;
    s_d    = s_q;
    if (sel == 2'sd1) begin
      w_d = v_d - two_s - t_term;
      s_d = s_q + t_term;
    end else if (sel == -2'sd1) begin
      w_d = v_d + two_s - t_term;
      s_d = s_q - t_term;
    end
  end

  sd_sqrt_select u_sel (
    .vest_i (vest),
    .s_o    (sel),
    .code_o (sel_code)
  );

  // Control FSM with the datapath registers and registered outputs.
  always_ff @(posedge i_clk) begin
    if (!i_Reset) begin
      state_q  <= ST_IDLE;
      w_q      <= '0;
      s_q      <= '0;
      j_q      <= '0;
      ld_cnt_q <= '0;
      valid_q  <= 1'b0;
      y_q      <= SD_ZERO;
      last_q   <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      y_q     <= SD_ZERO;
      last_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          busy_q <= 1'b0;
          // busy_q still high here on the o_last cycle, so no overlap.
          if (i_valid && i_first && !busy_q) begin
            w_q      <= x_term;
            s_q      <= '0;
            j_q      <= '0;
            ld_cnt_q <= CW'(1);
            err_q    <= x_ill;
            busy_q   <= 1'b1;
            state_q  <= (P == 1) ? ST_RUN : ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (i_valid) begin
            w_q      <= v_d;
            ld_cnt_q <= ld_cnt_q + CW'(1);
            err_q    <= err_q | x_ill;
            if (ld_cnt_q == CW'(P - 1)) begin
              state_q <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (i_valid) begin
            w_q     <= w_d;
            s_q     <= s_d;
            j_q     <= j_d;
            err_q   <= err_q | x_ill;
            valid_q <= 1'b1;
            y_q     <= sel_code;
            if (j_d == JW'(N - P)) begin
              state_q <= ST_FLUSH;
            end
          end
        end
        ST_FLUSH: begin
          w_q     <= w_d;
          s_q     <= s_d;
          j_q     <= j_d;
          valid_q <= 1'b1;
          y_q     <= sel_code;
          if (j_d == JW'(N)) begin
            last_q  <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_valid = valid_q;
  assign o_y     = y_q;
  assign o_last  = last_q;
  assign o_busy  = busy_q;
  assign o_err   = err_q;

endmodule

// File: tb/tb_online_sqrt_n.sv
// Directed and random checks of online_sqrt_n at N=8/P=1 and N=16/P=2.
// Latency: not applicable.
// Backpressure: stall inserted by deasserting i_valid in one scenario.
module tb_online_sqrt_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       rst_n;
  logic       sel;
  logic       drv_valid;
  logic       drv_first;
  logic [1:0] drv_x;

  logic       a_valid_o, a_last_o, a_busy_o, a_err_o;
  logic [1:0] a_y_o;
  logic       b_valid_o, b_last_o, b_busy_o, b_err_o;
  logic [1:0] b_y_o;

  online_sqrt_n #(.N(8), .P(1), .GUARD(3)) dut_a (
    .i_clk   (clk),
    .i_Reset (rst_n),
    .i_valid (drv_valid && !sel),
    .i_first (drv_first),
    .i_x     (drv_x),
    .o_valid (a_valid_o),
    .o_y     (a_y_o),
    .o_last  (a_last_o),
    .o_busy  (a_busy_o),
    .o_err   (a_err_o)
  );

  online_sqrt_n #(.N(16), .P(2), .GUARD(3)) dut_b (
    .i_clk   (clk),
    .i_Reset (rst_n),
    .i_valid (drv_valid && sel),
    .i_first (drv_first),
    .i_x     (drv_x),
    .o_valid (b_valid_o),
    .o_y     (b_y_o),
    .o_last  (b_last_o),
    .o_busy  (b_busy_o),
    .o_err   (b_err_o)
  );

  logic       m_valid, m_last, m_busy, m_err;
  logic [1:0] m_y;
  assign m_valid = sel ? b_valid_o : a_valid_o;
  assign m_last  = sel ? b_last_o  : a_last_o;
  assign m_busy  = sel ? b_busy_o  : a_busy_o;
  assign m_err   = sel ? b_err_o   : a_err_o;
  assign m_y     = sel ? b_y_o     : a_y_o;

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int code_val(input logic [1:0] c);
    case (c)
      2'b01:   return 1;
      2'b10:   return -1;
      2'b00:   return 0;
      default: return 9;
    endcase
  endfunction

  // Output monitor, sampled on the falling edge.
  int mon_dig[$];
  int mon_cyc[$];
  int mon_err[$];
  int last_cyc, last_idx, last_cnt, busy_rise, busy_fall;

  task automatic mon_clear();
    mon_dig.delete();
    mon_cyc.delete();
    mon_err.delete();
    last_cyc  = -1;
    last_idx  = -1;
    last_cnt  = 0;
    busy_rise = -1;
    busy_fall = -1;
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      mon_dig.push_back(code_val(m_y));
      mon_cyc.push_back(cyc);
      mon_err.push_back(int'(m_err));
      if (m_last) begin
        last_cyc = cyc;
        last_idx = mon_dig.size();
      end
    end
    if (m_last) last_cnt++;
    if (m_busy && busy_rise < 0) busy_rise = cyc;
    if (!m_busy && busy_rise >= 0 && busy_fall < 0) busy_fall = cyc;
  end

  // Reference recurrence on integers scaled by 2^F, wrapped to 3+F bits.
  function automatic longint wrapw(input longint x, input int bits);
    longint m;
    m = x & ((longint'(1) << bits) - 1);
    if (((m >> (bits - 1)) & 1) != 0) m = m - (longint'(1) << bits);
    return m;
  endfunction

  function automatic void sqrt_model(input int n, input int p, input int xd [16], output int sd [16]);
    int     f, bits, xi, sj;
    longint one, w, s, v, vest, t;
    f    = n + p + 3;
    bits = f + 3;
    one  = longint'(1) << f;
    w    = 0;
    s    = 0;
    for (int k = 0; k < 16; k++) sd[k] = 0;
    for (int k = 1; k <= p; k++) w = wrapw(2 * w + xd[k-1] * (one >> p), bits);
    for (int j = 1; j <= n; j++) begin
      xi   = (j + p <= n) ? xd[j+p-1] : 0;
      v    = wrapw(2 * w + xi * (one >> p), bits);
      vest = v >>> (f - 2);
      sj   = (vest >= 2) ? 1 : ((vest < -2) ? -1 : 0);
      t    = one >> j;
      w    = wrapw(v - sj * (2 * s + sj * t), bits);
      s    = wrapw(s + sj * t, bits);
      sd[j-1] = sj;
    end
  endfunction

  // Drives one operand (optional stall after digit st_after) and waits for completion.
  task automatic run_op(input int n, input int p, input logic [1:0] d [16],
                        input int st_after, input int st_len, output int c0);
    int t;
    mon_clear();
    c0 = cyc;
    for (int k = 0; k < n; k++) begin
      drv_valid = 1'b1;
      drv_first = (k == 0);
      drv_x     = d[k];
      @(posedge clk); #1;
      if (k + 1 == st_after) begin
        drv_valid = 1'b0;
        drv_first = 1'b0;
        drv_x     = 2'b00;
        repeat (st_len) begin @(posedge clk); #1; end
      end
    end
    drv_valid = 1'b0;
    drv_first = 1'b0;
    drv_x     = 2'b00;
    t = 0;
    while ((last_cyc < 0 || busy_fall < 0) && t < n + p + 40) begin
      @(posedge clk); #1;
      t++;
    end
    check_eq("op_done", longint'(last_cyc >= 0 && busy_fall >= 0), 1);
  endtask

  task automatic verify(input string tag, input int n, input int p, input int e [16],
                        input int c0, input int st_after, input int st_len);
    int extra;
    extra = (st_after < n) ? st_len : 0;
    check_eq({tag, " ndig"}, mon_dig.size(), n);
    check_eq({tag, " last_idx"}, last_idx, n);
    check_eq({tag, " last_cnt"}, last_cnt, 1);
    check_eq({tag, " last_cyc"}, last_cyc, c0 + n + p + extra);
    check_eq({tag, " busy_rise"}, busy_rise, c0 + 1);
    check_eq({tag, " busy_fall"}, busy_fall, c0 + n + p + extra + 1);
    for (int k = 0; k < n && k < mon_dig.size(); k++) begin
      check_eq($sformatf("%s dig%0d", tag, k + 1), mon_dig[k], e[k]);
      check_eq($sformatf("%s cyc%0d", tag, k + 1), mon_cyc[k],
               c0 + p + k + 1 + ((k + 1 + p > st_after) ? st_len : 0));
    end
  endtask

  function automatic longint root_scaled(input int n);
    longint r;
    r = 0;
    for (int k = 0; k < n && k < mon_dig.size(); k++) r += mon_dig[k] * (longint'(1) << (n - 1 - k));
    return r;
  endfunction

  logic [1:0] op1 [16] = '{2'b01, 2'b00, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 2'b01,
                          2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
  logic [1:0] op2 [16] = '{2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00,
                          2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
  logic [1:0] opz [16] = '{default: 2'b00};
  logic [1:0] ope [16];
  logic [1:0] opr [16];
  int exp1 [16] = '{1, 1, -1, -1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
  int exp2 [16] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
  int expz [16] = '{default: 0};
  int xd [16];
  int sd [16];
  int c0, vr, nbad;
  longint rt, diff;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n     = 1'b0;
    sel       = 1'b0;
    drv_valid = 1'b0;
    drv_first = 1'b0;
    drv_x     = 2'b00;
    mon_clear();
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst a_valid", a_valid_o, 0);
    check_eq("rst a_y", a_y_o, 0);
    check_eq("rst a_last", a_last_o, 0);
    check_eq("rst a_busy", a_busy_o, 0);
    check_eq("rst a_err", a_err_o, 0);
    check_eq("rst b_valid", b_valid_o, 0);
    check_eq("rst b_busy", b_busy_o, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // X = 0.31640625 -> root 0.5625 = +1,+1,-1,-1,0,0,0,0
    run_op(8, 1, op1, 99, 0, c0);
    verify("op1", 8, 1, exp1, c0, 99, 0);
    check_eq("op1 root", root_scaled(8), 144);

    // X = 0.25 -> root 0.5
    run_op(8, 1, op2, 99, 0, c0);
    verify("op2", 8, 1, exp2, c0, 99, 0);
    check_eq("op2 root", root_scaled(8), 128);

    run_op(8, 1, opz, 99, 0, c0);
    verify("zero", 8, 1, expz, c0, 99, 0);

    // Same operand, 3-cycle stall after digit 4.
    run_op(8, 1, op1, 4, 3, c0);
    verify("stall", 8, 1, exp1, c0, 4, 3);

    // Reset after the third result digit.
    mon_clear();
    c0 = cyc;
    for (int k = 0; k < 5; k++) begin
      drv_valid = 1'b1;
      drv_first = (k == 0);
      drv_x     = op1[k];
      if (k == 4) rst_n = 1'b0;
      @(posedge clk); #1;
    end
    check_eq("abort a_valid", a_valid_o, 0);
    check_eq("abort a_y", a_y_o, 0);
    check_eq("abort a_last", a_last_o, 0);
    check_eq("abort a_busy", a_busy_o, 0);
    check_eq("abort a_err", a_err_o, 0);
    rst_n     = 1'b1;
    drv_valid = 1'b0;
    drv_first = 1'b0;
    drv_x     = 2'b00;
    repeat (6) begin @(posedge clk); #1; end
    check_eq("abort ndig", mon_dig.size(), 3);
    if (mon_dig.size() >= 3) check_eq("abort dig3", mon_dig[2], -1);
    run_op(8, 1, op2, 99, 0, c0);
    verify("post_rst", 8, 1, exp2, c0, 99, 0);

    // Illegal code on digit 5 is taken as 0 (which op1 has there anyway).
    for (int k = 0; k < 16; k++) ope[k] = op1[k];
    ope[4] = 2'b11;
    run_op(8, 1, ope, 99, 0, c0);
    verify("err", 8, 1, exp1, c0, 99, 0);
    for (int k = 0; k < 8 && k < mon_err.size(); k++)
      check_eq($sformatf("err flag dig%0d", k + 1), mon_err[k], (k >= 3) ? 1 : 0);
    check_eq("err sticky idle", a_err_o, 1);
    run_op(8, 1, op2, 99, 0, c0);
    verify("err_clr", 8, 1, exp2, c0, 99, 0);
    if (mon_err.size() > 0) check_eq("err cleared", mon_err[0], 0);

    // N=16, P=2: random operands in [1/4,1) against the reference recurrence.
    sel = 1'b1;
    @(posedge clk); #1;
    for (int r = 0; r < 200; r++) begin
      vr = int'($urandom_range(65535, 16384));
      for (int k = 0; k < 16; k++) begin
        xd[k]  = (vr >> (15 - k)) & 1;
        opr[k] = (xd[k] != 0) ? 2'b01 : 2'b00;
      end
      sqrt_model(16, 2, xd, sd);
      run_op(16, 2, opr, 99, 0, c0);
      check_eq($sformatf("rnd%0d ndig", r), mon_dig.size(), 16);
      nbad = 0;
      for (int k = 0; k < 16 && k < mon_dig.size(); k++)
        if (mon_dig[k] != sd[k]) nbad++;
      check_eq($sformatf("rnd%0d x=%0d digit_mismatches", r, vr), nbad, 0);
      rt   = root_scaled(16);
      diff = rt * rt - (longint'(vr) << 16);
      check_eq($sformatf("rnd%0d x=%0d accuracy", r, vr),
               longint'(diff <= (longint'(1) << 18) && diff >= -(longint'(1) << 18)), 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
